// File: rtl/bus_arbiter.sv
// bus_arbiter: N-channel request arbiter merging bus masters onto one
// downstream port, one transaction in flight (IDLE -> ADDR -> RESP).
// Optional macro BUS_ARBITER_RR_EN selects round-robin arbitration;
// when undefined, fixed priority (lowest index wins) is used.
module bus_arbiter #(
  parameter int NCH     = 2,
  parameter int AW      = 64,
  parameter int DW      = 64,
  parameter int TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    req,
  input  logic [NCH*AW-1:0] req_addr,
  input  logic [NCH*DW-1:0] req_wdata,
  input  logic [NCH-1:0]    req_we,
  input  logic [NCH*2-1:0]  req_size,
  output logic [NCH-1:0]    grant,
  output logic [NCH-1:0]    done,
  output logic              err,
  output logic [DW-1:0]     rdata,
  output logic              a_valid,
  input  logic              a_ready,
  output logic [AW-1:0]     a_addr,
  output logic [DW-1:0]     a_wdata,
  output logic              a_we,
  output logic [1:0]        a_size,
  input  logic              d_valid,
  input  logic              d_error,
  input  logic [DW-1:0]     d_data,
  output logic              busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  logic [1:0]     r_state;
  logic [NCH-1:0] r_grant;
  logic [NCH-1:0] r_done;
  logic           r_err;
  logic [DW-1:0]  r_rdata;
  logic [AW-1:0]  r_addr;
  logic [DW-1:0]  r_wdata;
  logic           r_we;
  logic [1:0]     r_size;
  logic [CW-1:0]  r_cnt;

  logic [PW-1:0]  w_win_idx;
  logic [NCH-1:0] w_win_onehot;
  logic [AW-1:0]  w_sel_addr;
  logic [DW-1:0]  w_sel_wdata;
  logic           w_sel_we;
  logic [1:0]     w_sel_size;
  logic           w_timeout;
  logic           w_resp_fire;
  logic           w_done_fire;

`ifdef BUS_ARBITER_RR_EN
  logic [PW-1:0]  r_ptr;
  logic [PW-1:0]  r_owner;
  logic [PW-1:0]  w_hi_idx;
  logic [PW-1:0]  w_lo_idx;
  logic           w_hi_found;

  // Round-robin: first requester above the last winner, else lowest at/below it.
  always_comb begin
    w_hi_idx   = '0;
    w_lo_idx   = '0;
    w_hi_found = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (req[i] && (PW'(i) > r_ptr)) begin
        w_hi_idx   = PW'(i);
        w_hi_found = 1'b1;
      end
      if (req[i] && (PW'(i) <= r_ptr)) begin
        w_lo_idx = PW'(i);
      end
    end
    w_win_idx = w_hi_found ? w_hi_idx : w_lo_idx;
  end

  // Pointer tracks the owner and advances only when its done is issued.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr   <= '0;
      r_owner <= '0;
    end else begin
      if (r_state == ST_IDLE && |req) begin
        r_owner <= w_win_idx;
      end
      if (w_done_fire) begin
        r_ptr <= r_owner;
      end
    end
  end
`else
  // Fixed priority: lowest requesting index wins.
  always_comb begin
    w_win_idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (req[i]) begin
        w_win_idx = PW'(i);
      end
    end
  end
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_onehot
      assign w_win_onehot[gi] = (w_win_idx == PW'(gi)) && req[gi];
    end
  endgenerate

  // Mux the winning channel's request fields for latching.
  always_comb begin
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_we    = 1'b0;
    w_sel_size  = '0;
    for (int i = 0; i < NCH; i++) begin
      if (w_win_onehot[i]) begin
        w_sel_addr  = req_addr[i*AW +: AW];
        w_sel_wdata = req_wdata[i*DW +: DW];
        w_sel_we    = req_we[i];
        w_sel_size  = req_size[i*2 +: 2];
      end
    end
  end

  assign w_timeout   = (TIMEOUT > 0) && (r_state != ST_IDLE) && (r_cnt == TO_LAST);
  assign w_resp_fire = (r_state == ST_RESP) && d_valid;
  assign w_done_fire = w_resp_fire || w_timeout;

  // Main transaction FSM: grant, address phase, response or timeout.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_done  <= '0;
      r_err   <= 1'b0;
      r_rdata <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_size  <= '0;
      r_cnt   <= '0;
    end else begin
      r_done <= '0;
      if ((r_state != ST_IDLE) && (TIMEOUT > 0)) begin
        r_cnt <= r_cnt + 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (|req) begin
            r_grant <= w_win_onehot;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
            r_we    <= w_sel_we;
            r_size  <= w_sel_size;
            r_cnt   <= '0;
            r_state <= ST_ADDR;
          end
        end
        ST_ADDR, ST_RESP: begin
          if (w_resp_fire) begin
            r_done  <= r_grant;
            r_rdata <= d_data;
            r_err   <= d_error;
            r_grant <= '0;
            r_state <= ST_IDLE;
          end else if (w_timeout) begin
            r_done  <= r_grant;
            r_rdata <= '0;
            r_err   <= 1'b1;
            r_grant <= '0;
            r_state <= ST_IDLE;
          end else if ((r_state == ST_ADDR) && a_ready) begin
            r_state <= ST_RESP;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign grant   = r_grant;
  assign done    = r_done;
  assign err     = r_err;
  assign rdata   = r_rdata;
  assign a_valid = (r_state == ST_ADDR);
  assign a_addr  = r_addr;
  assign a_wdata = r_wdata;
  assign a_we    = r_we;
  assign a_size  = r_size;
  assign busy    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed scoreboard bench for bus_arbiter (NCH=2, TIMEOUT=8).
`timescale 1ns/1ps
module tb_bus_arbiter;
  localparam int NCH = 2;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int TIMEOUT = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NCH-1:0]    req;
  logic [NCH*AW-1:0] req_addr;
  logic [NCH*DW-1:0] req_wdata;
  logic [NCH-1:0]    req_we;
  logic [NCH*2-1:0]  req_size;
  logic [NCH-1:0]    grant;
  logic [NCH-1:0]    done;
  logic              err;
  logic [DW-1:0]     rdata;
  logic              a_valid;
  logic              a_ready;
  logic [AW-1:0]     a_addr;
  logic [DW-1:0]     a_wdata;
  logic              a_we;
  logic [1:0]        a_size;
  logic              d_valid;
  logic              d_error;
  logic [DW-1:0]     d_data;
  logic              busy;

  bus_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_we(req_we), .req_size(req_size),
    .grant(grant), .done(done), .err(err), .rdata(rdata),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr),
    .a_wdata(a_wdata), .a_we(a_we), .a_size(a_size),
    .d_valid(d_valid), .d_error(d_error), .d_data(d_data), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NCH-1:0] grant;
    logic [AW-1:0]  addr;
    logic           we;
    logic [DW-1:0]  wdata;
    logic [1:0]     size;
    logic [DW-1:0]  rdata;
    logic           err;
  } exp_t;

  exp_t sb_q[$];
  int errors = 0;
  int checks = 0;

  logic [AW-1:0] ch_addr  [NCH];
  logic [DW-1:0] ch_wdata [NCH];
  logic          ch_we    [NCH];
  logic [1:0]    ch_size  [NCH];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [AW-1:0] addr, input logic we,
                        input logic [DW-1:0] wdata, input logic [1:0] size);
    ch_addr[ch]  = addr;
    ch_we[ch]    = we;
    ch_wdata[ch] = wdata;
    ch_size[ch]  = size;
    for (int i = 0; i < NCH; i++) begin
      req_addr[i*AW +: AW]  = ch_addr[i];
      req_wdata[i*DW +: DW] = ch_wdata[i];
      req_we[i]             = ch_we[i];
      req_size[i*2 +: 2]    = ch_size[i];
    end
  endtask

  function automatic exp_t make_exp(input int w, input logic [DW-1:0] rd, input logic e);
    exp_t x;
    x.grant    = '0;
    x.grant[w] = 1'b1;
    x.addr     = ch_addr[w];
    x.we       = ch_we[w];
    x.wdata    = ch_wdata[w];
    x.size     = ch_size[w];
    x.rdata    = rd;
    x.err      = e;
    return x;
  endfunction

  // Called in an IDLE cycle with req already driven; w is the expected winner.
  task automatic do_txn(input string name, input int w, input int ready_dly, input int resp_dly,
                        input logic [DW-1:0] ddata, input logic derr);
    exp_t e;
    sb_q.push_back(make_exp(w, ddata, derr));
    check({name, "_pre_a_valid"}, a_valid, 1'b0);
    check({name, "_pre_grant"}, grant, '0);
    tick();
    check({name, "_grant"}, grant, sb_q[0].grant);
    check({name, "_a_valid"}, a_valid, 1'b1);
    check({name, "_a_addr"}, a_addr, sb_q[0].addr);
    check({name, "_a_we"}, a_we, sb_q[0].we);
    check({name, "_a_wdata"}, a_wdata, sb_q[0].wdata);
    check({name, "_a_size"}, a_size, sb_q[0].size);
    check({name, "_busy"}, busy, 1'b1);
    for (int c = 0; c < ready_dly; c++) begin
      a_ready = 1'b0;
      tick();
      check({name, "_stall_a_valid"}, a_valid, 1'b1);
      check({name, "_stall_a_addr"}, a_addr, sb_q[0].addr);
      check({name, "_stall_done"}, done, '0);
    end
    a_ready = 1'b1;
    tick();
    a_ready = 1'b0;
    check({name, "_resp_a_valid"}, a_valid, 1'b0);
    check({name, "_resp_busy"}, busy, 1'b1);
    for (int c = 0; c < resp_dly; c++) begin
      check({name, "_wait_done"}, done, '0);
      tick();
    end
    d_valid = 1'b1;
    d_data  = ddata;
    d_error = derr;
    tick();
    d_valid = 1'b0;
    d_error = 1'b0;
    e = sb_q.pop_front();
    check({name, "_done"}, done, e.grant);
    check({name, "_rdata"}, rdata, e.rdata);
    check({name, "_err"}, err, e.err);
    check({name, "_grant_clr"}, grant, '0);
    check({name, "_busy_clr"}, busy, 1'b0);
    $display("txn %s: winner=%0d addr=%0h done=%b rdata=%0h err=%b", name, w, e.addr, done, rdata, err);
  endtask

  initial begin
    exp_t e;
    rst_n = 1'b0; req = '0; req_addr = '0; req_wdata = '0; req_we = '0; req_size = '0;
    a_ready = 1'b0; d_valid = 1'b0; d_error = 1'b0; d_data = '0;
    for (int i = 0; i < NCH; i++) set_ch(i, '0, 1'b0, '0, 2'd0);
    tick();
    tick();
    check("rst_grant", grant, '0);
    check("rst_done", done, '0);
    check("rst_err", err, 1'b0);
    check("rst_rdata", rdata, '0);
    check("rst_a_valid", a_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    tick();

    // Single read on channel 1
    set_ch(1, 64'h8000_0010, 1'b0, '0, 2'd3);
    req = 2'b10;
    do_txn("read1", 1, 0, 0, 64'hDEAD_BEEF, 1'b0);
    req = '0;
    tick();

    // Reset so the arbitration pointer starts at 0
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;

    // Simultaneous requests held for three transactions
    set_ch(0, 64'h1000, 1'b0, '0, 2'd2);
    set_ch(1, 64'h2000, 1'b0, '0, 2'd2);
    req = 2'b11;
`ifdef BUS_ARBITER_RR_EN
    do_txn("arb_a", 1, 0, 0, 64'hA1, 1'b0);
    do_txn("arb_b", 0, 0, 0, 64'hA2, 1'b0);
    do_txn("arb_c", 1, 0, 0, 64'hA3, 1'b0);
`else
    do_txn("arb_a", 0, 0, 0, 64'hA1, 1'b0);
    do_txn("arb_b", 0, 0, 0, 64'hA2, 1'b0);
    do_txn("arb_c", 0, 0, 0, 64'hA3, 1'b0);
`endif
    req = '0;
    tick();

    // a_ready held low five cycles
    set_ch(0, 64'h3000, 1'b0, '0, 2'd1);
    req = 2'b01;
    do_txn("stall", 0, 5, 0, 64'h55, 1'b0);
    req = '0;
    tick();

    // Timeout with no d_valid
    set_ch(0, 64'h4000, 1'b0, '0, 2'd3);
    req = 2'b01;
    sb_q.push_back(make_exp(0, '0, 1'b1));
    tick();
    check("to_a_valid", a_valid, 1'b1);
    a_ready = 1'b1;
    tick();
    a_ready = 1'b0;
    req = '0;
    for (int c = 1; c <= 7; c++) begin
      check("to_wait_done", done, '0);
      tick();
    end
    e = sb_q.pop_front();
    check("to_done", done, e.grant);
    check("to_err", err, e.err);
    check("to_rdata", rdata, e.rdata);
    $display("txn timeout: done=%b err=%b rdata=%0h", done, err, rdata);
    tick();
    tick();
    d_valid = 1'b1;
    d_data  = 64'h99;
    tick();
    d_valid = 1'b0;
    check("to_stray_done", done, '0);
    check("to_stray_busy", busy, 1'b0);
    check("to_stray_rdata", rdata, '0);

    // Reset while in RESP, then a late response
    set_ch(1, 64'h5000, 1'b0, '0, 2'd2);
    req = 2'b10;
    tick();
    a_ready = 1'b1;
    tick();
    a_ready = 1'b0;
    check("mrst_busy", busy, 1'b1);
    rst_n = 1'b0;
    req = '0;
    tick();
    rst_n = 1'b1;
    d_valid = 1'b1;
    d_data  = 64'h77;
    tick();
    d_valid = 1'b0;
    check("mrst_done", done, '0);
    check("mrst_grant", grant, '0);
    check("mrst_a_valid", a_valid, 1'b0);
    check("mrst_busy_clr", busy, 1'b0);
    check("mrst_err", err, 1'b0);
    check("mrst_rdata", rdata, '0);
    $display("txn reset-in-resp: done=%b busy=%b", done, busy);

    // Write with bus error, granted normally after the reset
    set_ch(0, 64'h6000, 1'b1, 64'h1234, 2'd3);
    req = 2'b01;
    do_txn("write", 0, 0, 1, 64'hCAFE, 1'b1);
    req = '0;
    tick();

    check("sb_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
